// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - reconstructs four hex digits from a scanned 7-segment bus
//
// Ports:
//   segclk      segment clock, all logic on its rising edge
//   clr         synchronous active-high reset, highest priority
//   seg[6:0]    segment LEDs, active-low, bit0 = a ... bit6 = g
//   an[3:0]     anode enables, active-low, bit3 = left ... bit0 = right
//   digits[15:0] committed digit values, [15:12] left ... [3:0] right
//   valid[3:0]  position has committed at least once since reset
//   blank[3:0]  committed code for the position was all segments off
//   frame_pulse one-cycle pulse per complete in-order left-to-right scan
//   bad_code    sticky, unrecognised segment pattern seen
//   seq_err     sticky, illegal anode pattern or out-of-order scan

module seg_scan_decoder #(
   parameter int STABLE_COUNT = 2
) (
   input  logic        segclk,
   input  logic        clr,
   input  logic [6:0]  seg,
   input  logic [3:0]  an,
   output logic [15:0] digits,
   output logic [3:0]  valid,
   output logic [3:0]  blank,
   output logic        frame_pulse,
   output logic        bad_code,
   output logic        seq_err
);

   localparam logic [2:0] STABLE = 3'(STABLE_COUNT);

   typedef enum logic [1:0] {
      LEFT     = 2'd0,
      MIDLEFT  = 2'd1,
      MIDRIGHT = 2'd2,
      RIGHT    = 2'd3
   } pos_t;

   // The bus is captured first, so every output lands one edge after the
   // edge that sampled it.
   logic [6:0] seg_q;
   logic [3:0] an_q;

   pos_t expect_q, expect_d;
   logic chain_q, chain_d;    // every visit since the last matched LEFT was in order
   logic pulse_d, seq_set;

   logic [4:0] cand_q [4];
   logic [2:0] cnt_q  [4];

   logic       code_ok;
   logic [4:0] code;          // {blank, value}
   logic       is_idle, is_visit;
   pos_t       vpos;
   logic [1:0] vidx;          // bit index of the visited position (left = 3)
   logic       upd, commit;
   logic [2:0] cnt_new;

   always_comb begin
      code_ok = 1'b1;
      code    = 5'h00;
      case (seg_q)
         7'b1000000: code = 5'h00;
         7'b1111001: code = 5'h01;
         7'b0100100: code = 5'h02;
         7'b0110000: code = 5'h03;
         7'b0011001: code = 5'h04;
         7'b0010010: code = 5'h05;
         7'b0000010: code = 5'h06;
         7'b1111000: code = 5'h07;
         7'b0000000: code = 5'h08;
         7'b0010000: code = 5'h09;
         7'b0001000: code = 5'h0a;
         7'b0000011: code = 5'h0b;
         7'b1000110: code = 5'h0c;
         7'b0100001: code = 5'h0d;
         7'b0000110: code = 5'h0e;
         7'b0001110: code = 5'h0f;
         7'b1111111: code = 5'h10;
         default:    code_ok = 1'b0;
      endcase
   end

   always_comb begin
      is_idle  = (an_q == 4'b1111);
      is_visit = 1'b1;
      vpos     = LEFT;
      case (an_q)
         4'b0111: vpos = LEFT;
         4'b1011: vpos = MIDLEFT;
         4'b1101: vpos = MIDRIGHT;
         4'b1110: vpos = RIGHT;
         default: is_visit = 1'b0;
      endcase
      vidx = ~vpos;
   end

   // Tracker next state. Illegal samples leave the expected position alone
   // but still break the in-order chain.
   always_comb begin
      expect_d = expect_q;
      chain_d  = chain_q;
      pulse_d  = 1'b0;
      seq_set  = 1'b0;
      if (is_idle) begin
         expect_d = LEFT;
         chain_d  = 1'b0;
      end else if (!is_visit) begin
         chain_d = 1'b0;
         seq_set = 1'b1;
      end else begin
         expect_d = pos_t'(vpos + 2'd1);
         if (vpos == expect_q) begin
            if (vpos == LEFT) chain_d = 1'b1;
            if (vpos == RIGHT) pulse_d = chain_q;
         end else begin
            chain_d = 1'b0;
            seq_set = 1'b1;
         end
      end
   end

   always_ff @(posedge segclk) begin
      if (clr) begin
         expect_q <= LEFT;
         chain_q  <= 1'b0;
      end else begin
         expect_q <= expect_d;
         chain_q  <= chain_d;
      end
   end

   // Debounce for the visited position; a bad code never touches it.
   always_comb begin
      upd = is_visit && code_ok;
      if (code == cand_q[vidx])
         cnt_new = (cnt_q[vidx] < STABLE) ? cnt_q[vidx] + 3'd1 : cnt_q[vidx];
      else
         cnt_new = 3'd1;
      commit = upd && (cnt_new == STABLE);
   end

   always_ff @(posedge segclk) begin
      if (clr) begin
         seg_q       <= 7'h7f;
         an_q        <= 4'hf;
         digits      <= 16'h0000;
         valid       <= 4'h0;
         blank       <= 4'h0;
         frame_pulse <= 1'b0;
         bad_code    <= 1'b0;
         seq_err     <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            cand_q[i] <= 5'h00;
            cnt_q[i]  <= 3'd0;
         end
      end else begin
         seg_q       <= seg;
         an_q        <= an;
         frame_pulse <= pulse_d;
         if (is_visit && !code_ok) bad_code <= 1'b1;
         if (seq_set) seq_err <= 1'b1;
         if (upd) begin
            cand_q[vidx] <= code;
            cnt_q[vidx]  <= cnt_new;
         end
         if (commit) begin
            digits[{vidx, 2'b00} +: 4] <= code[3:0];
            blank[vidx]                <= code[4];
            valid[vidx]                <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed self-checking bench for seg_scan_decoder

module tb_seg_scan_decoder;

   localparam logic [6:0] S0  = 7'b1000000;
   localparam logic [6:0] S5  = 7'b0010010;
   localparam logic [6:0] S9  = 7'b0010000;
   localparam logic [6:0] SB  = 7'b1111111;
   localparam logic [6:0] BAD = 7'b1010101;

   logic        segclk = 1'b0;
   logic        clr = 1'b1;
   logic [6:0]  seg = 7'h7f;
   logic [3:0]  an = 4'hf;
   logic [15:0] digits, digits1;
   logic [3:0]  valid, blank, valid1, blank1;
   logic        frame_pulse, bad_code, seq_err;
   logic        frame_pulse1, bad_code1, seq_err1;

   int checks = 0;
   int failures = 0;
   int pulses = 0;

   always #5 segclk = ~segclk;

   seg_scan_decoder #(.STABLE_COUNT(2)) dut (
      .segclk(segclk), .clr(clr), .seg(seg), .an(an),
      .digits(digits), .valid(valid), .blank(blank),
      .frame_pulse(frame_pulse), .bad_code(bad_code), .seq_err(seq_err)
   );

   seg_scan_decoder #(.STABLE_COUNT(1)) dut1 (
      .segclk(segclk), .clr(clr), .seg(seg), .an(an),
      .digits(digits1), .valid(valid1), .blank(blank1),
      .frame_pulse(frame_pulse1), .bad_code(bad_code1), .seq_err(seq_err1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply one sample, let it be captured, then observe #1 after the edge.
   task automatic drive(input logic [3:0] a, input logic [6:0] s);
      an  = a;
      seg = s;
      @(posedge segclk);
      #1;
      if (frame_pulse) pulses++;
   endtask

   // One in-order scan followed by an idle sample that flushes the RIGHT result.
   task automatic frame(input logic [6:0] s3, input logic [6:0] s2,
                        input logic [6:0] s1, input logic [6:0] s0);
      pulses = 0;
      drive(4'b0111, s3);
      drive(4'b1011, s2);
      drive(4'b1101, s1);
      drive(4'b1110, s0);
      drive(4'b1111, SB);
   endtask

   initial begin
      clr = 1'b1;
      drive(4'b1111, SB);
      drive(4'b1111, SB);
      check("rst_digits", 32'(digits), 32'h0000);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_blank", 32'(blank), 32'h0);
      check("rst_flags", {29'd0, frame_pulse, bad_code, seq_err}, 32'h0);
      clr = 1'b0;

      frame(S0, S0, S0, S5);
      check("f1_valid", 32'(valid), 32'h0);
      check("f1_pulse", 32'(pulses), 32'd1);
      check("f1_s1_digits", 32'(digits1), 32'h0005);
      check("f1_s1_valid", 32'(valid1), 32'hf);
      frame(S0, S0, S0, S5);
      check("f2_digits", 32'(digits), 32'h0005);
      check("f2_valid", 32'(valid), 32'hf);
      check("f2_pulse", 32'(pulses), 32'd1);
      check("f2_flags", {30'd0, bad_code, seq_err}, 32'h0);
      drive(4'b1111, SB);
      check("pulse_one_cycle", 32'(frame_pulse), 32'h0);

      frame(S0, S0, S0, S9);
      frame(S0, S0, S0, S5);
      check("glitch_rejected", 32'(digits), 32'h0005);
      frame(S0, S0, S0, S9);
      check("held9_one_frame", 32'(digits), 32'h0005);
      frame(S0, S0, S0, S9);
      check("held9_two_frames", 32'(digits), 32'h0009);

      frame(S0, SB, S0, S9);
      check("blank_one_frame", 32'(blank), 32'h0);
      frame(S0, SB, S0, S9);
      check("blank_two_frames", 32'(blank), 32'h4);
      check("blank_digits", 32'(digits), 32'h0009);

      frame(S0, SB, S0, BAD);
      check("bad_flag", 32'(bad_code), 32'h1);
      check("bad_digits", 32'(digits), 32'h0009);
      check("bad_pulse", 32'(pulses), 32'd1);
      frame(S0, SB, S0, S9);
      check("bad_sticky", 32'(bad_code), 32'h1);
      check("bad_no_seq", 32'(seq_err), 32'h0);

      pulses = 0;
      drive(4'b0111, S0);
      drive(4'b1101, S0);
      drive(4'b1110, S9);
      drive(4'b1111, SB);
      check("skip_seq_err", 32'(seq_err), 32'h1);
      check("skip_no_pulse", 32'(pulses), 32'd0);
      frame(S0, SB, S0, S9);
      check("resync_pulse", 32'(pulses), 32'd1);

      drive(4'b0111, S0);
      drive(4'b1011, SB);
      clr = 1'b1;
      drive(4'b1101, S0);
      check("midclr_digits", 32'(digits), 32'h0000);
      check("midclr_valid", 32'(valid), 32'h0);
      check("midclr_blank", 32'(blank), 32'h0);
      check("midclr_flags", {29'd0, frame_pulse, bad_code, seq_err}, 32'h0);
      clr = 1'b0;
      pulses = 0;
      drive(4'b1111, SB);
      drive(4'b1111, SB);
      drive(4'b1111, SB);
      check("post_clr_idle_flags", {30'd0, bad_code, seq_err}, 32'h0);
      check("post_clr_no_pulse", 32'(pulses), 32'd0);

      drive(4'b0011, S5);
      drive(4'b1111, SB);
      check("illegal_an_seq_err", 32'(seq_err), 32'h1);
      check("illegal_an_valid", 32'(valid), 32'h0);
      check("illegal_an_digits", 32'(digits), 32'h0000);
      check("illegal_an_s1_valid", 32'(valid1), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
